ripple_count_ctrl: RTL and testbench

Measurement controller that sequences the 4-bit asynchronous ripple counter as a gated event counter. It clears the counter, opens its count gate for a programmed number of system clocks, waits for ripple settling, and captures the result. While the gate is open it extends the 4-bit value with a synchronous wrap counter. The result is delivered on a valid/ready handshake to the system-clock side.

---
 rtl/ripple_count_ctrl.sv | 148 ++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl.sv
`default_nettype none
// ripple_count_ctrl: gates an external 4-bit ripple counter for a programmed window, extends
// it with a synchronous wrap counter, and returns the settled count on a valid/ready handshake.
module ripple_count_ctrl #(
  parameter int WIN_W       = 16,
  parameter int EXT_W       = 8,
  parameter int SETTLE      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIN_W-1:0]   win_len,
  output logic               busy,
  output logic               cnt_clr,
  output logic               cnt_gate,
  input  logic [3:0]         cnt_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [EXT_W+3:0]   res_count,
  output logic               res_ovf
);

  localparam int SETTLE_CYC = SETTLE + SYNC_STAGES;
  localparam int SW         = $clog2(SETTLE_CYC + 1);
  localparam int TW         = (WIN_W > SW) ? WIN_W : SW;
  localparam logic [TW-1:0] C_SETTLE_LAST = TW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t             state_q;
  logic [TW-1:0]      timer_q;
  logic [WIN_W-1:0]   win_q;
  logic [EXT_W-1:0]   ext_q, ext_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         sync_q [SYNC_STAGES];
  logic               q3_prev_q;
  logic               fall;
  logic               track;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      q3_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= cnt_q;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      q3_prev_q <= sync_q[SYNC_STAGES-1][3];
    end
  end

  // Include the increment pending this cycle so the capture pairs ext with the same q_sync sample.
  assign fall  = q3_prev_q & ~sync_q[SYNC_STAGES-1][3];
  assign track = (state_q == ST_GATE) || (state_q == ST_SETTLE);

  always_comb begin
    ext_d = ext_q;
    ovf_d = ovf_q;
    if (track && fall) begin
      if (&ext_q) ovf_d = 1'b1;
      else        ext_d = ext_q + EXT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      win_q     <= '0;
      ext_q     <= '0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      cnt_clr   <= 1'b1;
      cnt_gate  <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_clr  <= 1'b1;
          cnt_gate <= 1'b0;
          if (start) begin
            win_q   <= (win_len == '0) ? WIN_W'(1) : win_len;
            timer_q <= TW'(1);
            busy    <= 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          ext_q <= '0;
          ovf_q <= 1'b0;
          if (timer_q == '0) begin
            timer_q  <= TW'(win_q) - TW'(1);
            cnt_clr  <= 1'b0;
            cnt_gate <= 1'b1;
            state_q  <= ST_GATE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_GATE: begin
          ext_q <= ext_d;
          ovf_q <= ovf_d;
          if (timer_q == '0) begin
            timer_q  <= C_SETTLE_LAST;
            cnt_gate <= 1'b0;
            state_q  <= ST_SETTLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_SETTLE: begin
          ext_q <= ext_d;
          ovf_q <= ovf_d;
          if (timer_q == '0) begin
            res_count <= ovf_d ? '1 : {ext_d, sync_q[SYNC_STAGES-1]};
            res_ovf   <= ovf_d;
            res_valid <= 1'b1;
            cnt_clr   <= 1'b1;
            state_q   <= ST_HOLD;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_ctrl.sv
`default_nettype none
// tb_ripple_count_ctrl: directed bench with a behavioural ripple counter; a second instance
// with a 2-bit extension shares the stimulus to reach wrap-counter saturation.
module tb_ripple_count_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] win_len;
  logic        res_ready;

  logic        busy_a, clr_a, gate_a, valid_a, ovf_a;
  logic [11:0] count_a;
  logic        busy_b, clr_b, gate_b, valid_b, ovf_b;
  logic [5:0]  count_b;
  logic [3:0]  rc_a = 4'd0;
  logic [3:0]  rc_b = 4'd0;

  int ev_req  = 0;
  int ev_done = 0;
  int gap     = 0;
  logic fire;

  int ntot = 0;
  int nbad = 0;

  int          t_valid, n_gate;
  logic        busy1, busy_after, valid_after;
  logic [11:0] cap_a;
  logic [5:0]  cap_b;
  logic        cap_ovf_a, cap_ovf_b, cap_valid_b;
  int          hold_err;

  always #5 clk = ~clk;

  ripple_count_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len),
    .busy(busy_a), .cnt_clr(clr_a), .cnt_gate(gate_a), .cnt_q(rc_a),
    .res_valid(valid_a), .res_ready(res_ready), .res_count(count_a), .res_ovf(ovf_a)
  );

  ripple_count_ctrl #(.EXT_W(2)) u_ovf (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len),
    .busy(busy_b), .cnt_clr(clr_b), .cnt_gate(gate_b), .cnt_q(rc_b),
    .res_valid(valid_b), .res_ready(res_ready), .res_count(count_b), .res_ovf(ovf_b)
  );

  // Events land on falling clk edges, at least 4 clocks apart, only while the gate is open.
  assign fire = !clr_a && gate_a && (ev_done < ev_req) && (gap == 0);

  always @(negedge clk) begin
    if (clr_a) begin
      rc_a <= 4'd0; ev_done <= 0; gap <= 0;
    end else if (fire) begin
      rc_a <= rc_a + 4'd1; ev_done <= ev_done + 1; gap <= 3;
    end else if (gap > 0) begin
      gap <= gap - 1;
    end
    if (clr_b)     rc_b <= 4'd0;
    else if (fire) rc_b <= rc_b + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int win, input int nev, input logic rdy);
    int cyc;
    @(negedge clk);
    ev_req = nev; win_len = 16'(win); res_ready = rdy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy_a; cyc = 1; t_valid = 0; n_gate = 0;
    while (t_valid == 0 && cyc < 1000) begin
      if (gate_a) n_gate++;
      if (valid_a) begin
        t_valid = cyc; cap_a = count_a; cap_ovf_a = ovf_a;
        cap_b = count_b; cap_ovf_b = ovf_b; cap_valid_b = valid_b;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    if (t_valid == 0) chk("timeout_res_valid", 32'(cyc), 32'(0));
    if (rdy) begin
      @(posedge clk); #1;
      busy_after = busy_a; valid_after = valid_a;
    end
  endtask

  initial begin
    start = 1'b0; win_len = '0; res_ready = 1'b0; reset = 1'b0;

    #12 reset = 1'b1;
    #1;
    chk("rst_cnt_clr",   32'(clr_a),   32'(1));
    chk("rst_cnt_gate",  32'(gate_a),  32'(0));
    chk("rst_busy",      32'(busy_a),  32'(0));
    chk("rst_res_valid", 32'(valid_a), 32'(0));
    chk("rst_res_count", 32'(count_a), 32'(0));
    chk("rst_res_ovf",   32'(ovf_a),   32'(0));
    chk("rst_cnt_clr_b", 32'(clr_b),   32'(1));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run(20, 5, 1'b1);
    chk("m1_t_valid",     32'(t_valid),     32'(28));
    chk("m1_gate_cycles", 32'(n_gate),      32'(20));
    chk("m1_busy_cyc1",   32'(busy1),       32'(1));
    chk("m1_count",       32'(cap_a),       32'(5));
    chk("m1_ovf",         32'(cap_ovf_a),   32'(0));
    chk("m1_busy_after",  32'(busy_after),  32'(0));
    chk("m1_valid_after", 32'(valid_after), 32'(0));
    repeat (3) @(posedge clk);
    #1 chk("m1_count_retained", 32'(count_a), 32'(5));

    run(200, 37, 1'b1);
    chk("m2_t_valid", 32'(t_valid),   32'(208));
    chk("m2_count",   32'(cap_a),     32'(37));
    chk("m2_ovf",     32'(cap_ovf_a), 32'(0));
    chk("m2_count_b", 32'(cap_b),     32'(37));

    run(300, 70, 1'b1);
    chk("m3_count",   32'(cap_a),       32'(70));
    chk("m3_ovf",     32'(cap_ovf_a),   32'(0));
    chk("m3_valid_b", 32'(cap_valid_b), 32'(1));
    chk("m3_count_b", 32'(cap_b),       32'(6'h3F));
    chk("m3_ovf_b",   32'(cap_ovf_b),   32'(1));

    run(10, 3, 1'b1);
    chk("m4_count",   32'(cap_a),     32'(3));
    chk("m4_count_b", 32'(cap_b),     32'(3));
    chk("m4_ovf_b",   32'(cap_ovf_b), 32'(0));

    run(20, 4, 1'b0);
    chk("hold_t_valid", 32'(t_valid), 32'(28));
    chk("hold_count",   32'(cap_a),   32'(4));
    hold_err = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = (k == 3);
      win_len = 16'd7;
      @(posedge clk); #1;
      if (count_a !== 12'd4 || valid_a !== 1'b1 || clr_a !== 1'b1 ||
          busy_a !== 1'b1 || gate_a !== 1'b0)
        hold_err++;
    end
    start = 1'b0;
    chk("hold_stable_cycles", 32'(hold_err), 32'(0));
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_valid_after_accept", 32'(valid_a), 32'(0));
    chk("hold_busy_after_accept",  32'(busy_a),  32'(0));
    run(5, 2, 1'b1);
    chk("post_hold_t_valid", 32'(t_valid), 32'(13));
    chk("post_hold_count",   32'(cap_a),   32'(2));

    @(negedge clk);
    ev_req = 10; win_len = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("rg_in_gate", 32'(gate_a), 32'(1));
    #3 reset = 1'b1;
    #1;
    chk("rg_cnt_clr",   32'(clr_a),   32'(1));
    chk("rg_cnt_gate",  32'(gate_a),  32'(0));
    chk("rg_busy",      32'(busy_a),  32'(0));
    chk("rg_res_valid", 32'(valid_a), 32'(0));
    chk("rg_res_count", 32'(count_a), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    run(0, 1, 1'b1);
    chk("w0_gate_cycles", 32'(n_gate),    32'(1));
    chk("w0_t_valid",     32'(t_valid),   32'(9));
    chk("w0_count",       32'(cap_a),     32'(1));
    chk("w0_ovf",         32'(cap_ovf_a), 32'(0));

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
`default_nettype wire
